// File: rtl/servo_pkg.sv
// Shared types and constants for the four-channel servo sequencer.
package servo_pkg;

  typedef logic [7:0] angle_t;

  localparam angle_t ANGLE_MAX  = 8'd180;
  localparam angle_t ANGLE_HOME = 8'd90;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } state_e;

  function automatic angle_t clamp_angle(input angle_t a);
    angle_t r;
    if (a > ANGLE_MAX) begin
      r = ANGLE_MAX;
    end else begin
      r = a;
    end
    return r;
  endfunction

endpackage

// File: rtl/servo_sequencer_if.sv
// Control/status bundle of the servo sequencer: the controller is the master, the sequencer the slave.
interface servo_sequencer_if;
  import servo_pkg::*;

  logic       enable;
  angle_t     target_angle1;
  angle_t     target_angle2;
  angle_t     target_angle3;
  angle_t     target_angle4;
  logic [3:0] pwm;
  angle_t     cur_angle1;
  angle_t     cur_angle2;
  angle_t     cur_angle3;
  angle_t     cur_angle4;
  logic [3:0] at_target;
  logic       frame_tick;

  modport master (
    output enable, target_angle1, target_angle2, target_angle3, target_angle4,
    input  pwm, cur_angle1, cur_angle2, cur_angle3, cur_angle4, at_target, frame_tick
  );

  modport slave (
    input  enable, target_angle1, target_angle2, target_angle3, target_angle4,
    output pwm, cur_angle1, cur_angle2, cur_angle3, cur_angle4, at_target, frame_tick
  );

endinterface

// File: rtl/servo_slew_step.sv
// One slew step: moves cur toward target by at most step, never past it.
module servo_slew_step
  import servo_pkg::*;
(
  input  angle_t cur,
  input  angle_t target,
  input  angle_t step,
  output angle_t next_angle
);

  angle_t diff_s;

  // min(step, |target - cur|) applied in the direction of the target
  always_comb begin
    diff_s     = 8'd0;
    next_angle = cur;
    if (target > cur) begin
      diff_s     = target - cur;
      next_angle = (diff_s > step) ? cur + step : target;
    end else if (cur > target) begin
      diff_s     = cur - target;
      next_angle = (diff_s > step) ? cur - step : target;
    end else begin
      next_angle = cur;
    end
  end

endmodule

// File: rtl/servo_sequencer.sv
// Four-channel RC servo pulse sequencer, one channel per slot, four slots per frame.
// Optional slew limiting is enabled by defining SERVO_SLEW_EN.
module servo_sequencer
  import servo_pkg::*;
#(
  parameter int CYC_PER_US = 50,
  parameter int SLOT_US    = 5000,
  parameter int BASE_US    = 500,
  parameter int US_PER_DEG = 11,
  parameter int STEP_DEG   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  servo_sequencer_if.slave  bus
);

  localparam int SLOT_CYC = SLOT_US * CYC_PER_US;
  localparam int CNT_W    = ($clog2(SLOT_CYC + 1) > 18) ? $clog2(SLOT_CYC + 1) : 18;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t SLOT_LAST = cnt_t'(SLOT_CYC - 1);
  localparam cnt_t BASE_CYC  = cnt_t'(BASE_US * CYC_PER_US);
  localparam cnt_t DEG_CYC   = cnt_t'(US_PER_DEG * CYC_PER_US);
  localparam cnt_t CNT_ONE   = cnt_t'(1);
  localparam cnt_t CNT_ZERO  = cnt_t'(0);

`ifdef SERVO_SLEW_EN
  localparam angle_t STEP = angle_t'(STEP_DEG);
`else
  // All-ones step covers any clamped difference, so LOAD copies the target outright
  localparam angle_t STEP = angle_t'(STEP_DEG) | 8'hFF;
`endif

  state_e     state_q, state_d;
  logic [1:0] ch_q, ch_d;
  cnt_t       cnt_q, cnt_d;
  cnt_t       w_q, w_d;
  angle_t     cur_q [4];
  angle_t     cur_d [4];
  logic [3:0] pwm_q, pwm_d;
  logic       frame_tick_q, frame_tick_d;
  angle_t     tgt_s [4];
  angle_t     slew_next_s;

  assign tgt_s[0] = clamp_angle(bus.target_angle1);
  assign tgt_s[1] = clamp_angle(bus.target_angle2);
  assign tgt_s[2] = clamp_angle(bus.target_angle3);
  assign tgt_s[3] = clamp_angle(bus.target_angle4);

  servo_slew_step u_slew (
    .cur        (cur_q[ch_q]),
    .target     (tgt_s[ch_q]),
    .step       (STEP),
    .next_angle (slew_next_s)
  );

  // Next-state logic; the counter runs from PULSE entry to the end of GAP
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    cnt_d        = cnt_q;
    w_d          = w_q;
    cur_d        = cur_q;
    pwm_d        = 4'b0000;
    frame_tick_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = CNT_ZERO;
        if (bus.enable) begin
          state_d = LOAD;
          ch_d    = 2'd0;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        cur_d[ch_q] = slew_next_s;
        w_d         = BASE_CYC + cnt_t'(slew_next_s) * DEG_CYC;
        cnt_d       = CNT_ZERO;
        state_d     = PULSE;
      end
      PULSE: begin
        cnt_d = cnt_q + CNT_ONE;
        if ((cnt_q + CNT_ONE) >= w_q) begin
          state_d = GAP;
        end else begin
          state_d = PULSE;
        end
      end
      GAP: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q >= SLOT_LAST) begin
          cnt_d   = CNT_ZERO;
          ch_d    = ch_q + 2'd1;
          state_d = bus.enable ? LOAD : IDLE;
        end else begin
          state_d = GAP;
        end
      end
      default: begin
        state_d = IDLE;
        ch_d    = 2'd0;
        cnt_d   = CNT_ZERO;
      end
    endcase
    pwm_d        = (state_d == PULSE) ? (4'b0001 << ch_d) : 4'b0000;
    frame_tick_d = (state_d == LOAD) && (ch_d == 2'd0);
  end

  // State and output registers; reset parks every servo at home
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ch_q         <= 2'd0;
      cnt_q        <= CNT_ZERO;
      w_q          <= CNT_ZERO;
      pwm_q        <= 4'b0000;
      frame_tick_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cur_q[i] <= ANGLE_HOME;
      end
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      cnt_q        <= cnt_d;
      w_q          <= w_d;
      pwm_q        <= pwm_d;
      frame_tick_q <= frame_tick_d;
      cur_q        <= cur_d;
    end
  end

  assign bus.pwm        = pwm_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.cur_angle1 = cur_q[0];
  assign bus.cur_angle2 = cur_q[1];
  assign bus.cur_angle3 = cur_q[2];
  assign bus.cur_angle4 = cur_q[3];
  assign bus.at_target  = {cur_q[3] == tgt_s[3], cur_q[2] == tgt_s[2],
                           cur_q[1] == tgt_s[1], cur_q[0] == tgt_s[0]};

endmodule

// File: tb/tb_servo_sequencer.sv
// Scoreboard bench for servo_sequencer with scaled-down timing parameters.
module tb_servo_sequencer;

  localparam int CYC      = 1;
  localparam int SLOT     = 200;
  localparam int BASE     = 5;
  localparam int UPD      = 1;
  localparam int STEP     = 3;
  localparam int SLOT_CYC = SLOT * CYC + 1;

  typedef struct {
    int          ch;
    int          rise;
    int          width;
    logic [31:0] cur;
    logic [3:0]  at;
  } pulse_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_active = 1'b0;

  pulse_t exp_q[$];
  int     ft_q[$];
  int     m_cur[4];
  int     tgt[4];
  int     ch = 0;
  int     next_load = 0;

  servo_sequencer_if bus();

  servo_sequencer #(
    .CYC_PER_US (CYC),
    .SLOT_US    (SLOT),
    .BASE_US    (BASE),
    .US_PER_DEG (UPD),
    .STEP_DEG   (STEP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name, input logic [31:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got 0x%0h while nothing was expected (cycle %0d)", name, act, cyc);
  endtask

  function automatic logic [31:0] dut_cur();
    return {bus.cur_angle4, bus.cur_angle3, bus.cur_angle2, bus.cur_angle1};
  endfunction

  // Reference rules: clamp to 180, then either jump or slew by at most STEP
  function automatic int clampa(input int a);
    return (a > 180) ? 180 : a;
  endfunction

  function automatic int model_next(input int cur, input int t_raw);
    int t;
    t = clampa(t_raw);
`ifdef SERVO_SLEW_EN
    if (t > cur) return (t - cur > STEP) ? cur + STEP : t;
    if (cur > t) return (cur - t > STEP) ? cur - STEP : t;
    return cur;
`else
    return t;
`endif
  endfunction

  function automatic logic [31:0] pack_cur();
    return {8'(m_cur[3]), 8'(m_cur[2]), 8'(m_cur[1]), 8'(m_cur[0])};
  endfunction

  function automatic logic [3:0] model_at();
    logic [3:0] r;
    for (int n = 0; n < 4; n++) r[n] = (m_cur[n] == clampa(tgt[n]));
    return r;
  endfunction

  task automatic set_tgt(input int a0, input int a1, input int a2, input int a3);
    tgt[0] = a0; tgt[1] = a1; tgt[2] = a2; tgt[3] = a3;
    bus.target_angle1 = 8'(a0);
    bus.target_angle2 = 8'(a1);
    bus.target_angle3 = 8'(a2);
    bus.target_angle4 = 8'(a3);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic start_run();
    @(negedge clk);
    bus.enable = 1'b1;
    next_load  = cyc + 1;
    ch         = 0;
  endtask

  // Predict one slot from the targets in force during its LOAD cycle
  task automatic run_slot(input bit rnd, input bit drop);
    int     a;
    pulse_t p;
    wait_cyc(next_load - 1);
    if (ch == 0) ft_q.push_back(next_load);
    a         = model_next(m_cur[ch], tgt[ch]);
    m_cur[ch] = a;
    p.ch      = ch;
    p.rise    = next_load + 1;
    p.width   = (BASE + a * UPD) * CYC;
    p.cur     = pack_cur();
    p.at      = model_at();
    exp_q.push_back(p);
    if (drop) begin
      wait_cyc(next_load + 11);
      bus.enable = 1'b0;
    end else if (rnd) begin
      wait_cyc(next_load + int'($urandom_range(3, SLOT_CYC - 3)));
      set_tgt(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end
    next_load += SLOT_CYC;
    ch = (ch + 1) % 4;
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_exp_queue_empty"}, exp_q.size(), 0);
    check({tag, "_tick_queue_empty"}, ft_q.size(), 0);
    check({tag, "_no_pulse_open"}, {31'd0, mon_active}, 0);
    check({tag, "_pwm_idle"}, {28'd0, bus.pwm}, 0);
    check({tag, "_at_target"}, {28'd0, bus.at_target}, {28'd0, model_at()});
  endtask

  // Monitor: pops predictions whenever the DUT shows a tick or a pulse edge
  initial begin : monitor
    pulse_t e;
    int     rise_c;
    int     exp_w;
    int     act_ch;
    rise_c = 0;
    exp_w  = 0;
    act_ch = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_active = 1'b0;
      end else begin
        if (bus.frame_tick) begin
          if (ft_q.size() == 0) fail_evt("frame_tick_unexpected", cyc);
          else check("frame_tick_cycle", cyc, ft_q.pop_front());
        end
        if (!mon_active && bus.pwm != 4'b0000) begin
          mon_active = 1'b1;
          rise_c     = cyc;
          if (exp_q.size() == 0) begin
            fail_evt("pwm_unexpected", {28'd0, bus.pwm});
            exp_w = -1;
          end else begin
            e      = exp_q.pop_front();
            exp_w  = e.width;
            act_ch = e.ch;
            check("pwm_channel", {28'd0, bus.pwm}, 32'd1 << act_ch);
            check("pulse_rise_cycle", cyc, e.rise);
            check("cur_angles", dut_cur(), e.cur);
            check("at_target", {28'd0, bus.at_target}, {28'd0, e.at});
          end
        end else if (mon_active) begin
          if (bus.pwm == 4'b0000) begin
            if (exp_w >= 0) check("pulse_width", cyc - rise_c, exp_w);
            mon_active = 1'b0;
          end else if ($countones(bus.pwm) != 1) begin
            fail_evt("pwm_not_onehot", {28'd0, bus.pwm});
          end
        end
      end
    end
  end

  initial begin : stimulus
    rst_n      = 1'b0;
    bus.enable = 1'b0;
    set_tgt(90, 90, 90, 90);
    for (int i = 0; i < 4; i++) m_cur[i] = 90;
    repeat (3) @(negedge clk);
    check("reset_pwm", {28'd0, bus.pwm}, 0);
    check("reset_cur", dut_cur(), 32'h5a5a5a5a);
    check("reset_frame_tick", {31'd0, bus.frame_tick}, 0);
    check("reset_at_target", {28'd0, bus.at_target}, 32'h0000000f);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("idle_pwm", {28'd0, bus.pwm}, 0);

    // Extremes and clamping, then held targets so any slewing is visible
    set_tgt(0, 200, 93, 90);
    start_run();
    for (int s = 0; s < 16; s++) run_slot(1'b0, 1'b0);
    for (int s = 0; s < 40; s++) run_slot(1'b1, 1'b0);

    // Enable dropped early in a pulse: slot completes, then the FSM idles
    run_slot(1'b0, 1'b1);
    wait_cyc(next_load + 60);
    check_drained("drop1");

    start_run();
    for (int s = 0; s < 12; s++) run_slot(1'b1, 1'b0);
    run_slot(1'b0, 1'b1);
    wait_cyc(next_load + 60);
    check_drained("drop2");

    // Asynchronous reset in the middle of a pulse
    set_tgt(180, 180, 180, 180);
    start_run();
    run_slot(1'b0, 1'b0);
    wait_cyc(next_load - SLOT_CYC + 3);
    check("pre_reset_pwm", {28'd0, bus.pwm}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_pwm", {28'd0, bus.pwm}, 0);
    check("async_reset_cur", dut_cur(), 32'h5a5a5a5a);
    check("async_reset_frame_tick", {31'd0, bus.frame_tick}, 0);
    exp_q.delete();
    ft_q.delete();
    repeat (5) @(negedge clk);
    check("reset_hold_pwm", {28'd0, bus.pwm}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
